// File: rtl/udp_tx_machine.sv
// Builds a 60-byte Ethernet/IPv4/UDP frame around one 32-bit payload word and
// serves it byte-addressed to the MAC TX side; IP checksum is summed serially first.
module udp_tx_machine #(
    parameter logic [47:0] SRC_MAC  = 48'h00_0A_35_00_00_01,
    parameter logic [31:0] SRC_IP   = 32'hC0A8_010A,
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [7:0]  TTL      = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_vld,
    input  logic [31:0] send_data,
    input  logic [47:0] dst_mac,
    input  logic [31:0] dst_ip,
    input  logic [15:0] dst_port,
    output logic        send_busy,
    output logic        tx_vld,
    output logic [10:0] tx_count,
    input  logic [10:0] tx_addr,
    input  logic        tx_adv,
    input  logic        tx_busy,
    input  logic        tx_last,
    output logic [7:0]  tx_data
);

    typedef enum logic [2:0] {IDLE, CSUM, FOLD1, FOLD2, REQ, SEND} state_t;

    state_t      state;
    state_t      state_next;
    logic [19:0] acc;
    logic [19:0] acc_fold;
    logic [3:0]  widx;
    logic [15:0] ident;
    logic [15:0] csum;
    logic [31:0] lat_data;
    logic [47:0] lat_mac;
    logic [31:0] lat_ip;
    logic [15:0] lat_port;
    logic [15:0] lat_ident;

    logic [4:0]  hdr_off;
    logic [15:0] hdr_cur;
    logic [2:0]  dmac_idx;
    logic [2:0]  smac_idx;
    logic [1:0]  pay_idx;

    // IPv4 header as ten 16-bit words; word 5 is the checksum slot.
    function automatic logic [15:0] hdr_word(input logic [3:0]  idx,
                                             input logic [15:0] id,
                                             input logic [31:0] dip,
                                             input logic [15:0] ck);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h4500;
            4'd1:    w = 16'h0020;
            4'd2:    w = id;
            4'd3:    w = 16'h4000;
            4'd4:    w = {TTL, 8'h11};
            4'd5:    w = ck;
            4'd6:    w = SRC_IP[31:16];
            4'd7:    w = SRC_IP[15:0];
            4'd8:    w = dip[31:16];
            4'd9:    w = dip[15:0];
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    function automatic logic [19:0] fold_carry(input logic [19:0] a);
        return {4'h0, a[15:0]} + {16'h0000, a[19:16]};
    endfunction

    function automatic logic [7:0] byte_of(input logic [15:0] w, input logic lo);
        return lo ? w[7:0] : w[15:8];
    endfunction

    assign acc_fold = fold_carry(acc);
    assign tx_count = 11'd60;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (send_vld) state_next = CSUM;
            CSUM:    if (widx == 4'd9) state_next = FOLD1;
            FOLD1:   state_next = FOLD2;
            FOLD2:   state_next = REQ;
            REQ:     if (!tx_busy) state_next = SEND;
            SEND:    if (tx_adv && tx_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        send_busy = (state != IDLE);
        tx_vld    = (state == REQ) && !tx_busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ident <= 16'h0000;
            acc   <= 20'h00000;
            widx  <= 4'd0;
        end else begin
            unique case (state)
                IDLE: if (send_vld) begin
                    acc  <= 20'h00000;
                    widx <= 4'd0;
                end
                CSUM: begin
                    acc  <= acc + {4'h0, hdr_word(widx, lat_ident, lat_ip, 16'h0000)};
                    widx <= widx + 4'd1;
                end
                FOLD1:   acc <= acc_fold;
                FOLD2:   acc <= acc_fold;
                SEND:    if (tx_adv && tx_last) ident <= ident + 16'd1;
                default: ;
            endcase
        end
    end

    // Frame fields carry no reset: they are only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && send_vld) begin
            lat_data  <= send_data;
            lat_mac   <= dst_mac;
            lat_ip    <= dst_ip;
            lat_port  <= dst_port;
            lat_ident <= ident;
        end
        if (state == FOLD2) csum <= ~acc_fold[15:0];
    end

    // Address arithmetic is done modulo the low bits; each range is short enough.
    assign hdr_off  = tx_addr[4:0] - 5'd14;
    assign hdr_cur  = hdr_word(hdr_off[4:1], lat_ident, lat_ip, csum);
    assign dmac_idx = 3'd5 - tx_addr[2:0];
    assign smac_idx = 3'd3 - tx_addr[2:0];
    assign pay_idx  = 2'd1 - tx_addr[1:0];

    always_comb begin
        tx_data = 8'h00;
        if (tx_addr < 11'd6)        tx_data = lat_mac[{dmac_idx, 3'b000} +: 8];
        else if (tx_addr < 11'd12)  tx_data = SRC_MAC[{smac_idx, 3'b000} +: 8];
        else if (tx_addr == 11'd12) tx_data = 8'h08;
        else if (tx_addr == 11'd13) tx_data = 8'h00;
        else if (tx_addr < 11'd34)  tx_data = byte_of(hdr_cur, hdr_off[0]);
        else if (tx_addr == 11'd34) tx_data = SRC_PORT[15:8];
        else if (tx_addr == 11'd35) tx_data = SRC_PORT[7:0];
        else if (tx_addr == 11'd36) tx_data = lat_port[15:8];
        else if (tx_addr == 11'd37) tx_data = lat_port[7:0];
        else if (tx_addr == 11'd39) tx_data = 8'h0C;
        else if (tx_addr >= 11'd42 && tx_addr < 11'd46)
                                    tx_data = lat_data[{pay_idx, 3'b000} +: 8];
    end

endmodule

// File: tb/tb_udp_tx_machine.sv
// Scoreboarded bench for udp_tx_machine: stimulus queues reference frames, an
// eth-like monitor reads each offered frame back byte by byte and compares.
module tb_udp_tx_machine;

    localparam logic [47:0] SRC_MAC  = 48'h00_0A_35_00_00_01;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_010A;
    localparam logic [15:0] SRC_PORT = 16'd5000;
    localparam logic [7:0]  TTL      = 8'd64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send_vld = 1'b0;
    logic [31:0] send_data = 32'h0;
    logic [47:0] dst_mac = 48'h0;
    logic [31:0] dst_ip = 32'h0;
    logic [15:0] dst_port = 16'h0;
    logic        send_busy;
    logic        tx_vld;
    logic [10:0] tx_count;
    logic [10:0] tx_addr = 11'h0;
    logic        tx_adv = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_last = 1'b0;
    logic [7:0]  tx_data;

    udp_tx_machine dut (
        .clk(clk), .reset(reset), .send_vld(send_vld), .send_data(send_data),
        .dst_mac(dst_mac), .dst_ip(dst_ip), .dst_port(dst_port),
        .send_busy(send_busy), .tx_vld(tx_vld), .tx_count(tx_count),
        .tx_addr(tx_addr), .tx_adv(tx_adv), .tx_busy(tx_busy),
        .tx_last(tx_last), .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit abort = 1'b0;
    logic [15:0]  model_ident = 16'h0;
    logic [479:0] exp_frames[$];
    int           exp_cycles[$];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Ones-complement sum of the ten header words with a zero checksum slot.
    function automatic logic [15:0] ip_csum(input logic [15:0] id, input logic [31:0] ip);
        logic [15:0] w[10];
        int unsigned s;
        s = 0;
        w = '{16'h4500, 16'h0020, id, 16'h4000, {TTL, 8'h11}, 16'h0000,
              SRC_IP[31:16], SRC_IP[15:0], ip[31:16], ip[15:0]};
        foreach (w[i]) s += 32'(w[i]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic logic [479:0] build_frame(input logic [31:0] d, input logic [47:0] m,
                                                 input logic [31:0] ip, input logic [15:0] p,
                                                 input logic [15:0] id);
        logic [15:0] ck;
        ck = ip_csum(id, ip);
        return {m, SRC_MAC, 16'h0800,
                16'h4500, 16'h0020, id, 16'h4000, TTL, 8'h11, ck, SRC_IP, ip,
                SRC_PORT, p, 16'h000C, 16'h0000, d, 112'h0};
    endfunction

    task automatic send_frame(input logic [31:0] d, input logic [47:0] m, input logic [31:0] ip,
                              input logic [15:0] p, input int hold, input bit expect_frame);
        logic [63:0] r64;
        @(negedge clk);
        chk(!send_busy, "busy_before_accept", 64'(send_busy), 0);
        send_vld = 1'b1; send_data = d; dst_mac = m; dst_ip = ip; dst_port = p;
        if (expect_frame) begin
            exp_frames.push_back(build_frame(d, m, ip, p, model_ident));
            exp_cycles.push_back(cyc + 13 + hold);
            model_ident++;
        end
        if (hold > 0) tx_busy = 1'b1;
        @(negedge clk);
        send_vld = 1'b0;
        r64 = {$urandom(), $urandom()};
        send_data = $urandom(); dst_mac = r64[47:0]; dst_ip = $urandom(); dst_port = 16'($urandom());
        chk(send_busy, "busy_rise", 64'(send_busy), 1);
        if (hold > 0) begin
            repeat (12 + hold) @(negedge clk);
            tx_busy = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (send_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(!send_busy, name, 64'(send_busy), 0);
    endtask

    // tx_vld protocol: never with tx_busy, never two cycles in a row.
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (tx_vld) begin
                chk(!tx_busy, "vld_while_busy", 64'(tx_busy), 0);
                chk(!prev, "vld_back_to_back", 64'(prev), 0);
            end
            prev = tx_vld;
        end
    end

    // eth-side monitor: pops the expected frame on tx_vld and reads it back.
    initial begin
        logic [479:0] f;
        int  ec;
        bit  aborted;
        forever begin
            @(negedge clk); #2;
            if (tx_vld) begin
                if (exp_frames.size() == 0) begin
                    chk(1'b0, "unexpected_tx_vld", 64'(cyc), 0);
                end else begin
                    f  = exp_frames.pop_front();
                    ec = exp_cycles.pop_front();
                    chk(cyc == ec, "tx_vld_cycle", 64'(cyc), 64'(ec));
                    chk(tx_count == 11'd60, "tx_count", 64'(tx_count), 60);
                    aborted = 1'b0;
                    for (int i = 0; i < 60; i++) begin
                        @(negedge clk);
                        if (abort) begin
                            aborted = 1'b1;
                            break;
                        end
                        tx_addr = 11'(i);
                        tx_last = (i == 59);
                        tx_adv  = (i == 59) ? 1'b1 : 1'($urandom_range(0, 1));
                        #1 chk(tx_data == f[479 - 8*i -: 8], $sformatf("byte_%0d", i),
                               64'(tx_data), 64'(f[479 - 8*i -: 8]));
                    end
                    if (aborted) begin
                        tx_adv = 1'b0; tx_last = 1'b0; abort = 1'b0;
                    end else begin
                        @(negedge clk);
                        tx_adv = 1'b0; tx_last = 1'b0;
                        chk(!send_busy, "busy_fall", 64'(send_busy), 0);
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] r64;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk(!send_busy, "rst_send_busy", 64'(send_busy), 0);
        chk(!tx_vld, "rst_tx_vld", 64'(tx_vld), 0);
        chk(tx_count == 11'd60, "rst_tx_count", 64'(tx_count), 60);
        reset = 1'b0;

        send_frame(32'hDEADBEEF, 48'hFFFFFFFFFFFF, 32'hC0A80101, 16'h1234, 0, 1);
        wait_idle("idle_frame1");
        send_frame(32'hDEADBEEF, 48'hFFFFFFFFFFFF, 32'hC0A80101, 16'h1234, 0, 1);
        wait_idle("idle_frame2");

        send_frame(32'hCAFEF00D, 48'h0102030405A6, 32'h0A000001, 16'h0050, 20, 1);
        wait_idle("idle_busy_hold");

        send_frame(32'hA5A55A5A, 48'h112233445566, 32'hC0A80102, 16'hBEEF, 0, 1);
        repeat (25) @(negedge clk);
        send_vld = 1'b1; send_data = 32'h11111111;
        @(negedge clk);
        send_vld = 1'b0;
        wait_idle("idle_ignored_send");
        repeat (20) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            r64 = {$urandom(), $urandom()};
            send_frame($urandom(), r64[47:0], $urandom(), 16'($urandom()), $urandom_range(0, 3), 1);
            wait_idle("idle_random");
        end

        @(negedge clk);
        force dut.ident = 16'hFFFF;
        @(negedge clk);
        release dut.ident;
        model_ident = 16'hFFFF;
        send_frame(32'h01020304, 48'hFFFFFFFFFFFF, 32'hC0A80101, 16'h1234, 0, 1);
        wait_idle("idle_ident_ffff");
        send_frame(32'h05060708, 48'hFFFFFFFFFFFF, 32'hC0A80101, 16'h1234, 0, 1);
        wait_idle("idle_ident_wrap");
        send_frame(32'h0BADF00D, 48'h00000000BEEF, 32'hC0A80101, 16'h4321, 0, 1);
        wait_idle("idle_pre_reset");

        // Reset while summing: the frame is dropped and ident restarts.
        send_frame(32'h12345678, 48'hAABBCCDDEEFF, 32'hC0A80101, 16'h1234, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1; model_ident = 16'h0;
        @(negedge clk);
        chk(!send_busy, "csum_rst_busy", 64'(send_busy), 0);
        chk(!tx_vld, "csum_rst_vld", 64'(tx_vld), 0);
        reset = 1'b0;
        send_frame(32'hDEADBEEF, 48'hFFFFFFFFFFFF, 32'hC0A80101, 16'h1234, 0, 1);
        wait_idle("idle_after_csum_rst");

        // Reset while sending: the monitor abandons the frame in progress.
        send_frame(32'h87654321, 48'h665544332211, 32'hC0A80101, 16'h9999, 0, 1);
        repeat (30) @(negedge clk);
        abort = 1'b1; reset = 1'b1; model_ident = 16'h0;
        @(negedge clk);
        chk(!send_busy, "send_rst_busy", 64'(send_busy), 0);
        chk(!tx_vld, "send_rst_vld", 64'(tx_vld), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(32'hDEADBEEF, 48'hFFFFFFFFFFFF, 32'hC0A80101, 16'h1234, 0, 1);
        wait_idle("idle_after_send_rst");

        repeat (20) @(negedge clk);
        chk(exp_frames.size() == 0, "frames_outstanding", 64'(exp_frames.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/udp_tx_machine.md
# udp_tx_machine

Builds a minimum-size Ethernet/IPv4/UDP frame carrying one 32-bit payload word and serves it byte-by-byte to the MAC TX side of `eth`. It is the transmit counterpart of `udp_machine` and sits beside `arp_machine` on the MAC TX interface; the toplevel muxes the two onto `eth`. The IP header checksum is computed sequentially before the frame is offered. UDP checksum is sent as 0x0000. FCS and preamble are appended by `eth`.

## Interface
Parameters:
- `SRC_MAC`, 48'h00_0A_35_00_00_01, source MAC address.
- `SRC_IP`, 32'hC0A8_010A, source IPv4 address (192.168.1.10).
- `SRC_PORT`, 16'd5000, UDP source port.
- `TTL`, 8'd64, IPv4 time-to-live.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `send_vld` in 1: request to send `send_data`; sampled only in IDLE.
- `send_data` in 32: payload word, MSB byte transmitted first.
- `dst_mac` in 48: destination MAC, latched on accept.
- `dst_ip` in 32: destination IP, latched on accept.
- `dst_port` in 16: destination UDP port, latched on accept.
- `send_busy` out 1: high whenever the state is not IDLE.
- `tx_vld` out 1: one-cycle frame-start request to `eth`.
- `tx_count` out 11: frame length in bytes, constant 11'd60.
- `tx_addr` in 11: byte index requested by `eth`.
- `tx_adv` in 1: `eth` consumed the byte at `tx_addr`.
- `tx_busy` in 1: `eth` transmitter occupied.
- `tx_last` in 1: qualifies `tx_adv` on the final byte.
- `tx_data` out 8: byte at `tx_addr`, combinational from `tx_addr` and latched fields.

## Operation
- FSM states are IDLE, CSUM, FOLD1, FOLD2, REQ and SEND.
  - IDLE → CSUM when `send_vld`: latch `send_data`, `dst_*` and the current `ident`; clear the accumulator and word index.
  - CSUM: add one 16-bit header word per cycle into a 20-bit accumulator, with the checksum word taken as 0. Word order is 4500, 0020, ident, 4000, {TTL,11}, 0000, SRC_IP[31:16], SRC_IP[15:0], dst_ip[31:16], dst_ip[15:0]. After 10 words, go to FOLD1.
  - FOLD1: acc ← acc[15:0] + acc[19:16]. Go to FOLD2.
  - FOLD2: acc ← acc[15:0] + acc[19:16]; csum ← ~acc[15:0] of the result. Go to REQ.
  - REQ: wait while `tx_busy`. In the first cycle with `~tx_busy`, pulse `tx_vld` and go to SEND.
  - SEND: on `tx_adv & tx_last`, increment `ident` (16-bit, wraps FFFF→0000) and go to IDLE.
- Frame byte map (`tx_addr` → `tx_data`):
  - 0–5: dst_mac, MSB first.
  - 6–11: SRC_MAC.
  - 12–13: 08 00.
  - 14–33: IP header in the word order above, with the checksum at bytes 24–25.
  - 34–35: SRC_PORT.
  - 36–37: dst_port.
  - 38–39: 00 0C.
  - 40–41: 00 00.
  - 42–45: payload.
  - 46–59 and any address ≥60: 0x00.
- `send_vld` outside IDLE is ignored (no queueing).
- Latched fields are stable from accept until return to IDLE. `tx_data` is valid for any `tx_addr` in SEND and REQ.

## Timing
- Reset values: state IDLE, `send_busy`=0, `tx_vld`=0, `ident`=0, accumulator 0. `tx_count` is always 60.
- Accept at cycle 0. CSUM occupies cycles 1–10, FOLD1 cycle 11, FOLD2 cycle 12. With `tx_busy` low, `tx_vld`=1 in cycle 13.
- `send_busy` rises in cycle 1 and falls the cycle after `tx_adv & tx_last`. A new `send_vld` is accepted in that cycle at the earliest.
- `tx_vld` is never high for two consecutive cycles and never high while `tx_busy`=1.
- `tx_adv` without `tx_last` in SEND has no effect on state. Any `tx_adv` outside SEND is ignored.
- `reset` in any state returns to IDLE on the next edge, drops `tx_vld`, and clears `ident`. A frame in progress is abandoned.

## Test plan
- Reset, then `send_vld` with data 0xDEADBEEF, dst_ip C0A80101, dst_port 0x1234, dst_mac 0xFFFFFFFFFFFF, `tx_busy`=0 → `tx_vld` exactly at cycle 13 with `tx_count`=60. The byte dump 0–59 matches the map, bytes 24–25 = B7 71, bytes 42–45 = DE AD BE EF, bytes 46–59 = 00.
- Second identical send → bytes 18–19 = 00 01 and checksum bytes = B7 70.
- Hold `tx_busy`=1 for 20 cycles after FOLD2 → `tx_vld` stays low, then pulses exactly once in the first cycle `tx_busy`=0.
- Pulse `send_vld` with data 0x11111111 during SEND of frame A → ignored. Frame A payload is unchanged and only one `tx_vld` is issued.
- Force `ident`=FFFF by sending 65535 frames (or a backdoor load), then send twice → bytes 18–19 = FF FF, then 00 00.
- Assert `reset` in CSUM and again in SEND → next cycle IDLE, `send_busy`=0, `tx_vld`=0. The next frame carries ident 0000 and checksum B771.
